// File: rtl/dev_bus_arbiter_pkg.sv
// rtl/dev_bus_arbiter_pkg.sv - shared types and constants for the two-master device bus arbiter
package dev_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    localparam logic [11:0] LED_BASE = 12'hFF0;
    localparam logic [11:0] SW_BASE  = 12'hFE0;

endpackage

// File: rtl/dev_bus_arbiter_if.sv
// rtl/dev_bus_arbiter_if.sv - one master's request/ack register-port bundle
interface dev_bus_arbiter_if
    import dev_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, wdata, wen, input  ack, rdata);
    modport slave  (input  req, addr, wdata, wen, output ack, rdata);
endinterface

// File: rtl/dev_bus_arbiter_rr_arb2.sv
// rtl/dev_bus_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    // On contention the master that did not win last time gets the grant.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/dev_bus_arbiter.sv
// rtl/dev_bus_arbiter.sv - round-robin arbiter sharing the device register port between two masters
module dev_bus_arbiter
    import dev_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    dev_bus_arbiter_if.slave    m0,
    dev_bus_arbiter_if.slave    m1,
    output logic [ADDR_W-1:0]   dev_addr,
    output logic [DATA_W-1:0]   dev_wdata,
    output logic                dev_wen,
    input  logic [DATA_W-1:0]   dev_rdata,
    output logic                busy
);
    state_t     state;
    state_t     state_d;
    logic       last_gnt;
    logic       sel;
    logic [1:0] gnt;
    logic       win;
    logic       grant;

    rr_arb2 u_rr_arb2 (
        .req  ({m1.req, m0.req}),
        .last (last_gnt),
        .gnt  (gnt)
    );

    assign win  = gnt[1];
    assign busy = (state == ST_ACCESS) || (state == ST_RESP);

    always_comb begin
        state_d = state;
        grant   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|gnt) begin
                    grant   = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // dev_wen is loaded only on the grant edge, so it is high for the ACCESS cycle alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            sel       <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            dev_wen   <= 1'b0;
            m0.ack    <= 1'b0;
            m1.ack    <= 1'b0;
            m0.rdata  <= '0;
            m1.rdata  <= '0;
        end else begin
            dev_wen <= grant ? (win ? m1.wen : m0.wen) : 1'b0;
            if (grant) begin
                sel       <= win;
                last_gnt  <= win;
                dev_addr  <= win ? m1.addr  : m0.addr;
                dev_wdata <= win ? m1.wdata : m0.wdata;
            end
            m0.ack <= (state == ST_ACCESS) && !sel;
            m1.ack <= (state == ST_ACCESS) &&  sel;
            if ((state == ST_ACCESS) && !sel) begin
                m0.rdata <= dev_rdata;
            end
            if ((state == ST_ACCESS) && sel) begin
                m1.rdata <= dev_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dev_bus_arbiter.sv
// tb/tb_dev_bus_arbiter.sv - randomized and directed checks of dev_bus_arbiter against a transaction-level model
module tb_dev_bus_arbiter;
    import dev_bus_arbiter_pkg::*;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        wen;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] dev_addr;
    logic [15:0] dev_wdata;
    logic        dev_wen;
    logic [15:0] dev_rdata;
    logic        busy;
    logic [15:0] dev_leds = '0;
    logic [15:0] switches = '0;

    dev_bus_arbiter_if m0_if ();
    dev_bus_arbiter_if m1_if ();

    dev_bus_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_wen   (dev_wen),
        .dev_rdata (dev_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // LED/switch device: LEDs are write-only bits, switches read back one bit per address.
    assign dev_rdata = (dev_addr[11:4] == SW_BASE[11:4]) ? {15'b0, switches[dev_addr[3:0]]} : 16'h0000;
    always @(posedge clk) begin
        if (dev_wen && dev_addr[11:4] == LED_BASE[11:4]) dev_leds[dev_addr[3:0]] <= dev_wdata[0];
    end

    int checks = 0;
    int errors = 0;

    txn_t q0[$];
    txn_t q1[$];
    txn_t cur[2];
    bit   act[2];
    int   act_pct = 100;

    bit          p_valid = 1'b0;
    int          p_start = 0;
    int          p_who   = 0;
    txn_t        p_t;
    logic [15:0] p_rd;
    logic [15:0] e_rd[2];
    int          last_m  = 1;
    logic [15:0] mdl_leds = '0;
    int          k = 0;

    int ack_k[$];
    int ack_who[$];
    int wen_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, a, e, k);
        end
    endtask

    function automatic txn_t mk(input logic [11:0] a, input logic [15:0] d, input logic w);
        txn_t t;
        t.addr = a; t.wdata = d; t.wen = w;
        return t;
    endfunction

    function automatic logic [15:0] mdl_read(input logic [11:0] a);
        return (a[11:4] == SW_BASE[11:4]) ? {15'b0, switches[a[3:0]]} : 16'h0000;
    endfunction

    task automatic drive_masters();
        m0_if.req = act[0]; m0_if.addr = cur[0].addr; m0_if.wdata = cur[0].wdata; m0_if.wen = cur[0].wen;
        m1_if.req = act[1]; m1_if.addr = cur[1].addr; m1_if.wdata = cur[1].wdata; m1_if.wen = cur[1].wen;
    endtask

    // One clock cycle: compare DUT against the model, then update masters and the model's schedule.
    task automatic step();
        bit idle_now;
        int pick;
        @(negedge clk);
        if (p_valid && k == p_start + 1) e_rd[p_who] = p_rd;
        chk("busy",     busy,    p_valid);
        chk("dev_wen",  dev_wen, p_valid && k == p_start && p_t.wen);
        chk("m0_ack",   m0_if.ack, p_valid && k == p_start + 1 && p_who == 0);
        chk("m1_ack",   m1_if.ack, p_valid && k == p_start + 1 && p_who == 1);
        chk("m0_rdata", m0_if.rdata, e_rd[0]);
        chk("m1_rdata", m1_if.rdata, e_rd[1]);
        if (p_valid && k == p_start) begin
            chk("dev_addr",  dev_addr,  p_t.addr);
            chk("dev_wdata", dev_wdata, p_t.wdata);
        end
        if (m0_if.ack) begin ack_k.push_back(k); ack_who.push_back(0); end
        if (m1_if.ack) begin ack_k.push_back(k); ack_who.push_back(1); end
        if (dev_wen) wen_cycles++;

        idle_now = !p_valid;
        if (p_valid && k == p_start + 1) begin
            if (p_t.wen && p_t.addr[11:4] == LED_BASE[11:4]) mdl_leds[p_t.addr[3:0]] = p_t.wdata[0];
            act[p_who] = 1'b0;
            p_valid = 1'b0;
        end
        if (!act[0] && q0.size() > 0 && $urandom_range(99) < act_pct) begin cur[0] = q0.pop_front(); act[0] = 1'b1; end
        if (!act[1] && q1.size() > 0 && $urandom_range(99) < act_pct) begin cur[1] = q1.pop_front(); act[1] = 1'b1; end
        drive_masters();
        if (idle_now && (act[0] || act[1])) begin
            pick    = (act[0] && act[1]) ? (last_m == 1 ? 0 : 1) : (act[1] ? 1 : 0);
            p_who   = pick;
            p_t     = cur[pick];
            p_rd    = mdl_read(p_t.addr);
            p_start = k + 1;
            p_valid = 1'b1;
            last_m  = pick;
        end
        k++;
    endtask

    task automatic run_idle();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] || p_valid) && n < 4000) begin
            step();
            n++;
        end
        if (n >= 4000) begin
            checks++; errors++;
            $display("FAIL run_idle timeout actual=%0d required=<4000", n);
        end
        step();
    endtask

    task automatic clear_logs();
        ack_k.delete(); ack_who.delete(); wen_cycles = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_dev_wen"},  dev_wen, 0);
        chk({tag, "_dev_addr"}, dev_addr, 0);
        chk({tag, "_dev_wd"},   dev_wdata, 0);
        chk({tag, "_m0_ack"},   m0_if.ack, 0);
        chk({tag, "_m1_ack"},   m1_if.ack, 0);
        chk({tag, "_m0_rd"},    m0_if.rdata, 0);
        chk({tag, "_m1_rd"},    m1_if.rdata, 0);
    endtask

    // Asynchronous reset in the middle of the ACCESS cycle that follows a grant.
    task automatic reset_mid();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_mid");
        p_valid = 1'b0;
        e_rd[0] = '0;
        e_rd[1] = '0;
        last_m  = 1;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int k0;
        rst_n = 1'b0;
        act[0] = 1'b0; act[1] = 1'b0;
        cur[0] = mk(12'h000, 16'h0000, 1'b0);
        cur[1] = mk(12'h000, 16'h0000, 1'b0);
        e_rd[0] = '0; e_rd[1] = '0;
        drive_masters();
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // m0 write to LED 3
        clear_logs();
        q0.push_back(mk(12'hFF3, 16'h0001, 1'b1));
        k0 = k;
        run_idle();
        chk("t2_leds", dev_leds, 16'h0008);
        chk("t2_wen_cycles", wen_cycles, 1);
        chk("t2_latency", ack_k[0] - k0, 2);

        // m1 read of switch 5
        switches = 16'h0020;
        clear_logs();
        q1.push_back(mk(12'hFE5, 16'h0000, 1'b0));
        run_idle();
        chk("t3_m1_rdata", m1_if.rdata, 16'h0001);
        chk("t3_m0_rdata", m0_if.rdata, 16'h0000);
        chk("t3_ack_who", ack_who[0], 1);

        // both masters saturate the port
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(12'hFF0 + 12'(i), 16'h0001, 1'b1));
            q1.push_back(mk(12'hFE5, 16'h0000, 1'b0));
        end
        run_idle();
        chk("t4_ack_count", ack_who.size(), 8);
        for (int i = 0; i < 8; i++) chk("t4_order", ack_who[i], i % 2);
        for (int i = 0; i < 7; i++) chk("t4_spacing", ack_k[i+1] - ack_k[i], 3);

        // m1 arrives while m0 is in ACCESS
        clear_logs();
        q0.push_back(mk(12'hFF1, 16'h0000, 1'b1));
        step();
        q1.push_back(mk(12'hFE5, 16'h0000, 1'b0));
        run_idle();
        chk("t5_ack_count", ack_who.size(), 2);
        chk("t5_first", ack_who[0], 0);
        chk("t5_second", ack_who[1], 1);
        chk("t5_gap", ack_k[1] - ack_k[0], 3);
        chk("t5_wen_cycles", wen_cycles, 1);

        // reset during the ACCESS of a write to LED 7; request is held and reissued
        clear_logs();
        q0.push_back(mk(12'hFF7, 16'h0001, 1'b1));
        step();
        reset_mid();
        chk("t6_leds7_dropped", dev_leds[7], 1'b0);
        run_idle();
        chk("t6_leds7", dev_leds[7], 1'b1);
        chk("t6_ack_count", ack_who.size(), 1);

        // LED space does not read back
        clear_logs();
        q1.push_back(mk(12'hFF7, 16'h0001, 1'b1));
        q1.push_back(mk(12'hFF7, 16'h0000, 1'b0));
        run_idle();
        chk("t7_rdata", m1_if.rdata, 16'h0000);
        chk("t7_ack_count", ack_who.size(), 2);

        // randomized traffic with gaps
        act_pct  = 60;
        switches = 16'($urandom);
        for (int i = 0; i < 150; i++) begin
            for (int m = 0; m < 2; m++) begin
                logic [11:0] a;
                case ($urandom_range(2))
                    0:       a = {8'hFE, 4'($urandom)};
                    1:       a = {8'hFF, 4'($urandom)};
                    default: a = 12'($urandom);
                endcase
                if (m == 0) q0.push_back(mk(a, 16'($urandom), 1'($urandom)));
                else        q1.push_back(mk(a, 16'($urandom), 1'($urandom)));
            end
        end
        run_idle();
        chk("rand_leds", dev_leds, mdl_leds);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dev_bus_arbiter.md
Name: dev_bus_arbiter

Overview:
Two-master arbiter that shares the single device register port (12-bit addr, 16-bit wdata, wen, combinational rdata) between the CPU data port (m0) and an auxiliary master (m1, e.g. debug/loader).
- Each master issues one transaction per request: req held until ack.
- The arbiter grants round-robin and drives a registered device port for exactly one access cycle.
- It returns read data with a one-cycle ack pulse.
- Sits between the CPU/aux masters and the device (LED/switch) block in the SoC.

Parameters:
ADDR_W, 12, device address width
DATA_W, 16, data width

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
m0_req  input  1  master 0 request; held high until m0_ack seen
m0_addr  input  ADDR_W  master 0 address, stable while m0_req
m0_wdata  input  DATA_W  master 0 write data
m0_wen  input  1  master 0 write (1) / read (0)
m0_ack  output  1  one-cycle completion pulse to master 0
m0_rdata  output  DATA_W  master 0 read data, valid with m0_ack, held until next m0 ack
m1_req, m1_addr, m1_wdata, m1_wen, m1_ack, m1_rdata  same as m0, for master 1
dev_addr  output  ADDR_W  device address
dev_wdata  output  DATA_W  device write data
dev_wen  output  1  device write strobe
dev_rdata  input  DATA_W  device read data, combinational from dev_addr
busy  output  1  high in ACCESS and RESP

Behaviour:
- Interface fixed: one clock, clk; reset rst_n asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, last_gnt=1 (so m0 wins the first contention).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick a winner. Single requester wins outright. Both requesting: grant ~last_gnt.
  - Latch sel=winner, addr, wdata, wen of the winner into dev_addr/dev_wdata/wr_q. Set last_gnt=winner. Go to ACCESS.
  - No req: stay in IDLE; dev_wen=0.
- ACCESS (exactly 1 cycle):
  - dev_wen = wr_q; dev_addr and dev_wdata stable.
  - At the closing edge, capture dev_rdata into m{sel}_rdata, set m{sel}_ack=1, go to RESP.
  - On writes, rdata is still captured (don't-care value, but deterministic).
- RESP (1 cycle): m{sel}_ack high; other master's ack low; dev_wen=0. Next state IDLE, ack cleared.
- Master rule: req drops at the edge where ack is sampled high. The following IDLE cycle therefore never re-grants the same transaction.
- Latency: req high in IDLE cycle N -> dev access in N+1 -> ack in N+2. Throughput: one transaction per 3 cycles.
- Fairness: under continuous requests from both masters, grants alternate m0, m1, m0, ... Neither master waits more than one transaction.
- Requests during ACCESS/RESP are ignored, not lost: the master keeps req high and is arbitrated at the next IDLE.
- dev_wen is a registered single-cycle pulse, never high outside ACCESS.
- The non-selected master's rdata register is unchanged.
- Reset mid-transaction (any state): immediate return to IDLE with all outputs 0. The in-flight write is dropped if reset precedes the ACCESS edge. No ack is issued.
- Widths: no arithmetic; addr/data are passed through unmodified.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2), ADDR_W/DATA_W defaults, device map constants (LED base 0xFF0, switch base 0xFE0).
- Sub-module: rr_arb2 — combinational 2-way round-robin picker (req[1:0], last -> gnt[1:0]). The last_gnt register stays in the parent.

Test Plan:
- After reset: all outputs 0, busy=0. Assert m0 write addr 0xFF3 wdata 0x0001 -> dev_wen high exactly 1 cycle (N+1) with dev_addr=0xFF3; m0_ack at N+2; device leds=0x0008.
- m1 read addr 0xFE5 with switches=0x0020 -> m1_ack at N+2, m1_rdata=0x0001; m0_rdata unchanged.
- m0 and m1 both request in the same cycle, held continuously for 4 transactions each -> grant order m0, m1, m0, m1, ...; each transaction is 3 cycles.
- m1 requests while an m0 ACCESS is in progress -> m1 is served in the next IDLE; dev_wen never overlaps; exactly one ack per transaction.
- rst_n pulled low during ACCESS of a write to 0xFF7 -> outputs 0 asynchronously, no ack; after release, with req still high, the transaction reissues and completes with leds[7]=1.
- Write then read back the same LED address via m1 -> wdata 0x0001 followed by read at 0xFF7 returns 0x0000 (LED space does not read back); no protocol error.
